// File: rtl/dm_bus_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter.
// The DM window constant is also used by the M-stage address decode.
package dm_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_e;

    localparam logic [31:0] DM_WINDOW = 32'h3000;
    localparam logic [3:0]  CNT_MAX   = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == CNT_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/dm_bus_arbiter.sv
// Zero-latency arbiter for the single DM/bridge port: CPU M-stage vs DMA,
// with bounded DMA bursts, DMA starvation guard and DM-window check.
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter logic [31:0] DMA_ADDR_LIM = DM_WINDOW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_be,
    output logic        dma_gnt,
    output logic        dma_err,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] BURST_LIM  = 4'(MAX_BURST);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    arb_state_e state;
    logic [3:0] burst_cnt;
    logic [3:0] wait_cnt;

    logic locked;
    logic starved;
    logic dma_illegal;

    assign locked      = (state == ARB_DMA) && dma_req && (burst_cnt < BURST_LIM);
    assign starved     = (wait_cnt >= STARVE_LIM);
    assign dma_illegal = (dma_addr >= DMA_ADDR_LIM);

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign rdata     = mem_rdata;

    // Reset low suppresses every grant so nothing reaches memory.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (reset) begin
            if (locked || (dma_req && (starved || !cpu_req))) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_be    = cpu_be;
        end else if (dma_gnt && !dma_illegal) begin
            mem_en    = 1'b1;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_be    = dma_be;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            burst_cnt <= '0;
            wait_cnt  <= '0;
            dma_err   <= 1'b0;
        end else begin
            dma_err <= dma_gnt & dma_illegal;
            if (dma_gnt) begin
                burst_cnt <= (state == ARB_DMA) ? sat_inc(burst_cnt) : 4'd1;
                wait_cnt  <= '0;
            end else begin
                burst_cnt <= '0;
                if (dma_req) begin
                    wait_cnt <= sat_inc(wait_cnt);
                end
            end
            if (dma_gnt) begin
                state <= ARB_DMA;
            end else if (cpu_gnt) begin
                state <= ARB_CPU;
            end else begin
                state <= ARB_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: vector table, directed corner
// sequences and constrained-random traffic against a run-length model.
module tb_dm_bus_arbiter;

    localparam int MAXB   = 4;
    localparam int STARVE = 8;
    localparam logic [31:0] LIM = 32'h3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_gnt, cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic [3:0]  dma_be;
    logic        dma_gnt, dma_err;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dm_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_be(dma_be),
        .dma_gnt(dma_gnt), .dma_err(dma_err),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata)
    );

    // Data-memory stub, word-indexed by addr[9:2].
    logic [31:0] dm [0:255];
    logic        dm_clear;

    assign mem_rdata = dm[mem_addr[9:2]];

    always @(posedge clk) begin
        if (dm_clear) begin
            for (int i = 0; i < 256; i++) dm[i] <= '0;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b])
                    dm[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: consecutive DMA grants, DMA waiting cycles,
    // pending error pulse and expected memory image.
    int          n_tests;
    int          n_fail;
    int          run;
    int          waited;
    bit          err_q;
    bit          last_gc;
    bit          last_gd;
    logic [31:0] ref_dm [0:255];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm);
        bit          locked, starved, g_dma, g_cpu, illegal, en, we;
        logic [31:0] a, d;
        logic [3:0]  be;
        int          wexp;
        #1;
        locked  = (run > 0) && dma_req && (run < MAXB);
        starved = (waited >= STARVE);
        g_dma   = reset && (locked || (dma_req && (starved || !cpu_req)));
        g_cpu   = reset && !g_dma && cpu_req;
        illegal = (dma_addr >= LIM);
        en = 0; we = 0; a = '0; d = '0; be = '0;
        if (g_cpu) begin
            en = 1; we = cpu_we; a = cpu_addr; d = cpu_wdata; be = cpu_be;
        end else if (g_dma && !illegal) begin
            en = 1; we = dma_we; a = dma_addr; d = dma_wdata; be = dma_be;
        end
        wexp = (waited > 15) ? 15 : waited;
        chk({nm, ".cpu_gnt"},   32'(cpu_gnt),   32'(g_cpu));
        chk({nm, ".dma_gnt"},   32'(dma_gnt),   32'(g_dma));
        chk({nm, ".cpu_stall"}, 32'(cpu_stall), 32'(cpu_req && !g_cpu));
        chk({nm, ".dma_err"},   32'(dma_err),   32'(err_q));
        chk({nm, ".mem_en"},    32'(mem_en),    32'(en));
        chk({nm, ".mem_we"},    32'(mem_we),    32'(we));
        chk({nm, ".mem_addr"},  mem_addr,       a);
        chk({nm, ".mem_wdata"}, mem_wdata,      d);
        chk({nm, ".mem_be"},    32'(mem_be),    32'(be));
        chk({nm, ".wait_cnt"},  32'(dut.wait_cnt), 32'(wexp));
        if (en && !we) chk({nm, ".rdata"}, rdata, ref_dm[a[9:2]]);
        @(posedge clk);
        #1;
        last_gc = g_cpu;
        last_gd = g_dma;
        if (!reset) begin
            run = 0; waited = 0; err_q = 0;
        end else begin
            if (en && we)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_dm[a[9:2]][8*b +: 8] = d[8*b +: 8];
            err_q = g_dma && illegal;
            if (g_dma) begin
                run++; waited = 0;
            end else begin
                run = 0;
                if (dma_req) waited++;
            end
        end
    endtask

    typedef struct packed {
        bit c; bit d; bit ec; bit ed; bit es;
    } vec_t;

    vec_t tbl [10];

    initial begin
        n_tests = 0; n_fail = 0;
        run = 0; waited = 0; err_q = 0;
        last_gc = 0; last_gd = 0;
        for (int i = 0; i < 256; i++) ref_dm[i] = '0;
        dm_clear = 1'b1;
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_be = '0;

        tbl[0] = '{0, 1, 0, 1, 0};
        tbl[1] = '{1, 1, 0, 1, 1};
        tbl[2] = '{1, 1, 0, 1, 1};
        tbl[3] = '{1, 1, 0, 1, 1};
        tbl[4] = '{1, 1, 1, 0, 0};
        tbl[5] = '{0, 1, 0, 1, 0};
        tbl[6] = '{0, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 0, 0};
        tbl[8] = '{0, 1, 0, 1, 0};
        tbl[9] = '{0, 0, 0, 0, 0};

        @(posedge clk);
        #1;
        dm_clear = 1'b0;

        // reset state: no grants, stall follows cpu_req
        cpu_req = 1; dma_req = 1;
        #1;
        chk("rst.cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst.stall", 32'(cpu_stall), 32'd1);
        step("rst");
        cpu_req = 0; dma_req = 0;
        step("rst2");
        reset = 1'b1;

        // CPU-only store then load
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10;
        cpu_wdata = 32'hDEADBEEF; cpu_be = 4'hF;
        #1;
        chk("t1_sw.gnt", 32'(cpu_gnt), 32'd1);
        chk("t1_sw.stall", 32'(cpu_stall), 32'd0);
        step("t1_sw");
        cpu_we = 0; cpu_wdata = '0;
        #1;
        chk("t1_lw.gnt", 32'(cpu_gnt), 32'd1);
        chk("t1_lw.rdata", rdata, 32'hDEADBEEF);
        step("t1_lw");
        cpu_req = 0;
        step("t1_idle");

        // Burst lock and simultaneous-request table
        cpu_addr = 32'h20; dma_addr = 32'h100; dma_we = 0; dma_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            cpu_req = tbl[i].c;
            dma_req = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d.cpu_gnt", i), 32'(cpu_gnt), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d.dma_gnt", i), 32'(dma_gnt), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d.stall", i), 32'(cpu_stall), 32'(tbl[i].es));
            step($sformatf("tbl%0d", i));
        end

        // Starvation: DMA wins on its ninth waiting cycle
        for (int i = 0; i < 10; i++) begin
            cpu_req = 1;
            dma_req = (i <= 8);
            #1;
            chk($sformatf("t4_%0d.dma_gnt", i), 32'(dma_gnt), 32'(i == 8));
            chk($sformatf("t4_%0d.stall", i), 32'(cpu_stall), 32'(i == 8));
            step($sformatf("t4_%0d", i));
        end
        cpu_req = 0; dma_req = 0;
        step("t4_idle");

        // Illegal DMA write outside the DM window
        dma_req = 1; dma_we = 1; dma_addr = 32'h3004; dma_wdata = 32'h12345678;
        #1;
        chk("t5.dma_gnt", 32'(dma_gnt), 32'd1);
        chk("t5.mem_en", 32'(mem_en), 32'd0);
        step("t5");
        dma_req = 0; dma_we = 0;
        #1;
        chk("t5.err_pulse", 32'(dma_err), 32'd1);
        step("t5_err");
        #1;
        chk("t5.err_clear", 32'(dma_err), 32'd0);
        chk("t5.dm_word", dm[1], ref_dm[1]);
        step("t5_idle");

        // Reset at beat 2 of a DMA burst
        dma_req = 1; dma_addr = 32'h40;
        step("t6_b1");
        cpu_req = 1; reset = 1'b0;
        #1;
        chk("t6.cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("t6.dma_gnt", 32'(dma_gnt), 32'd0);
        chk("t6.mem_en", 32'(mem_en), 32'd0);
        chk("t6.stall", 32'(cpu_stall), 32'd1);
        step("t6_rst");
        reset = 1'b1;
        #1;
        chk("t6.rel_cpu", 32'(cpu_gnt), 32'd1);
        chk("t6.rel_dma", 32'(dma_gnt), 32'd0);
        step("t6_rel");
        cpu_req = 0; dma_req = 0;
        step("t6_idle");

        // Random traffic, requests held until granted
        last_gc = 1; last_gd = 1;
        for (int i = 0; i < 400; i++) begin
            if (!cpu_req || last_gc) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 32'($urandom_range(0, 255)) << 2;
                cpu_wdata = $urandom;
                cpu_be    = 4'($urandom_range(0, 15));
            end
            if (!dma_req || last_gd) begin
                dma_req   = ($urandom_range(0, 2) != 0);
                dma_we    = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0)
                    dma_addr = LIM + (32'($urandom_range(0, 63)) << 2);
                else
                    dma_addr = 32'($urandom_range(0, 255)) << 2;
                dma_wdata = $urandom;
                dma_be    = 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 59) != 0);
            step($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
